// File: rtl/freq_meas8.sv
// Period meter: counts clock cycles between rising edges of the asynchronous clockin.
// Build option: PERIOD_AVG_EN reports the truncated mean of four consecutive periods.
module freq_meas8 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clockin,
  output logic [7:0] dataout,
  output logic       valid,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    OVF   = 2'd2
  } state_e;

  state_e     state_q;
  logic [2:0] sync_q;
  logic       edge_w;
  logic [1:0] edge_dly_q;
  logic       edge_act_w;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] dataout_q;
  logic       valid_q;
  logic       overflow_q;

`ifdef PERIOD_AVG_EN
  logic [9:0] acc_q;
  logic [1:0] phase_q;
  logic [9:0] avg_sum_w;

  assign avg_sum_w = acc_q + {2'b00, cnt_q};
`endif

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect flop
  assign edge_w     = sync_q[1] & ~sync_q[2];
  // Two delay stages on the detected edge give valid on the 4th clock after sampling
  assign edge_act_w = edge_dly_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      edge_dly_q <= '0;
    end else begin
      sync_q     <= {sync_q[1:0], clockin};
      edge_dly_q <= {edge_dly_q[0], edge_w};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (edge_act_w)
      cnt_d = 8'd1;
    else if (cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dataout_q  <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PERIOD_AVG_EN
      acc_q      <= '0;
      phase_q    <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (edge_act_w)
            state_q <= COUNT;
        end
        COUNT: begin
          // An edge coinciding with saturation is a valid 255-cycle period
          if (edge_act_w) begin
`ifdef PERIOD_AVG_EN
            if (phase_q == 2'd3) begin
              dataout_q <= avg_sum_w[9:2];
              valid_q   <= 1'b1;
              acc_q     <= '0;
              phase_q   <= '0;
            end else begin
              acc_q   <= avg_sum_w;
              phase_q <= phase_q + 2'd1;
            end
`else
            dataout_q <= cnt_q;
            valid_q   <= 1'b1;
`endif
          end else if (cnt_q == 8'hFF) begin
            state_q    <= OVF;
            dataout_q  <= 8'hFF;
            valid_q    <= 1'b1;
            overflow_q <= 1'b1;
`ifdef PERIOD_AVG_EN
            acc_q      <= '0;
            phase_q    <= '0;
`endif
          end
        end
        OVF: begin
          // The edge leaving OVF closes an unmeasurable period, so it is not reported
          if (edge_act_w) begin
            state_q    <= COUNT;
            overflow_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataout  = dataout_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_meas8.sv
// Directed bench for freq_meas8: clockin periods driven as whole cycles, outputs
// sampled on the falling clock edge and checked against hand-computed values.
module tb_freq_meas8;

  logic       clock;
  logic       reset_n;
  logic       clockin;
  logic [7:0] dataout;
  logic       valid;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  freq_meas8 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clockin  (clockin),
    .dataout  (dataout),
    .valid    (valid),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clockin period of p clocks starting with a rising edge; collects valid pulses.
  task automatic run_period(input int p, output int nv, output int dv, output int vstep);
    nv = 0; dv = -1; vstep = -1;
    for (int i = 0; i < p; i++) begin
      @(posedge clock); #2;
      clockin = (i < p / 2) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (valid === 1'b1) begin
        nv++;
        dv = int'(dataout);
        if (vstep < 0) vstep = i;
      end
    end
  endtask

  task automatic hold_low(input int n, output int nv, output int dv);
    nv = 0; dv = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #2;
      clockin = 1'b0;
      @(negedge clock);
      if (valid === 1'b1) begin
        nv++;
        dv = int'(dataout);
      end
    end
  endtask

  initial begin
    int nv, dv, vs;
    reset_n = 1'b0;
    clockin = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_dataout", int'(dataout), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    repeat (5) @(posedge clock);

`ifdef PERIOD_AVG_EN
    // Intervals 10, 11, 12, 14 -> one valid with (47 >> 2) = 11
    run_period(10, nv, dv, vs);
    check("avg_first_edge_nv", nv, 0);
    run_period(11, nv, dv, vs);
    check("avg_edge2_nv", nv, 0);
    run_period(12, nv, dv, vs);
    check("avg_edge3_nv", nv, 0);
    run_period(14, nv, dv, vs);
    check("avg_edge4_nv", nv, 0);
    run_period(10, nv, dv, vs);
    check("avg_edge5_nv", nv, 1);
    check("avg_edge5_dv", dv, 11);
    check("avg_latency", vs, 5);
    check("avg_overflow", int'(overflow), 0);
    @(negedge clock);
    check("avg_hold", int'(dataout), 11);
`else
    // Steady period 10
    run_period(10, nv, dv, vs);
    check("p10_first_nv", nv, 0);
    run_period(10, nv, dv, vs);
    check("p10_nv", nv, 1);
    check("p10_dv", dv, 10);
    check("p10_latency", vs, 5);
    check("p10_overflow", int'(overflow), 0);
    for (int k = 0; k < 3; k++) begin
      run_period(10, nv, dv, vs);
      check("p10_steady_nv", nv, 1);
      check("p10_steady_dv", dv, 10);
    end

    // Switch to 37: the first 37-run edge closes the last 10-cycle interval
    run_period(37, nv, dv, vs);
    check("sw_tail_dv", dv, 10);
    run_period(37, nv, dv, vs);
    check("sw_p37_nv", nv, 1);
    check("sw_p37_dv", dv, 37);
    check("sw_hold", int'(dataout), 37);
    run_period(37, nv, dv, vs);
    check("sw_p37b_dv", dv, 37);

    // Stall clockin low
    hold_low(300, nv, dv);
    check("ovf_nv", nv, 1);
    check("ovf_dv", dv, 255);
    check("ovf_flag", int'(overflow), 1);
    run_period(20, nv, dv, vs);
    check("ovf_exit_nv", nv, 0);
    check("ovf_exit_flag", int'(overflow), 0);
    check("ovf_exit_hold", int'(dataout), 255);
    run_period(20, nv, dv, vs);
    check("ovf_after_nv", nv, 1);
    check("ovf_after_dv", dv, 20);

    // Exactly 255-cycle intervals: edge wins over saturation
    run_period(255, nv, dv, vs);
    check("p255_tail_dv", dv, 20);
    run_period(255, nv, dv, vs);
    check("p255_nv", nv, 1);
    check("p255_dv", dv, 255);
    check("p255_overflow", int'(overflow), 0);
    run_period(20, nv, dv, vs);
    check("p255b_dv", dv, 255);
    check("p255b_overflow", int'(overflow), 0);

    // Reset mid-period at period 20
    run_period(20, nv, dv, vs);
    check("pre_rst_dv", dv, 20);
    @(posedge clock); #2;
    clockin = 1'b1;
    repeat (8) @(posedge clock);
    #2;
    check("pre_rst_dataout", int'(dataout), 20);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dataout", int'(dataout), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    clockin = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    run_period(20, nv, dv, vs);
    check("post_rst_first_nv", nv, 0);
    check("post_rst_first_dataout", int'(dataout), 0);
    run_period(20, nv, dv, vs);
    check("post_rst_nv", nv, 1);
    check("post_rst_dv", dv, 20);
    run_period(20, nv, dv, vs);
    check("post_rst_dv2", dv, 20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
